// File: rtl/not_gate_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : not_gate_unit_pkg
// Purpose  : Default sizing constants shared by the inverter unit and its
//            activity counter.
// Revision : 1.0 - initial release
// ============================================================================
package not_gate_unit_pkg;

  localparam int c_DEF_WIDTH = 1;
  localparam int c_DEF_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/not_gate_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import not_gate_unit_pkg::*;
#(
  parameter int W = c_DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] c_MAX = '1;

  logic [W-1:0] r_cnt;

  // Reset beats clear, clear beats increment; the count holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/not_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : not_gate_unit
// Purpose  : Bitwise inverter with a registered copy and a toggle counter.
// Revision : 1.0 - initial release
// ============================================================================
module not_gate_unit
  import not_gate_unit_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int CNT_W = c_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_q,
  output logic             valid_q,
  input  logic             clr,
  output logic [CNT_W-1:0] tog_cnt
);

  logic [WIDTH-1:0] r_b_q;
  logic [WIDTH-1:0] r_b_prev;
  logic             r_valid_q;
  logic             w_toggle;

  assign b = ~a;

  // Reset value of b_q is the inverse of an all-zero input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b_q     <= '1;
      r_b_prev  <= '1;
      r_valid_q <= 1'b0;
    end else begin
      r_b_q     <= ~a;
      r_b_prev  <= r_b_q;
      r_valid_q <= 1'b1;
    end
  end

  assign w_toggle = r_valid_q && (r_b_q != r_b_prev);

  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_toggle),
    .cnt   (tog_cnt)
  );

  assign b_q     = r_b_q;
  assign valid_q = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_not_gate_unit.sv
`default_nettype none
// Bench for not_gate_unit: a WIDTH=1 instance and a WIDTH=4/CNT_W=2 instance
// checked against an edge-by-edge reference model.
module tb_not_gate_unit;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        a1 = 1'b0;
  logic [3:0]  a4 = 4'h0;
  logic        b1, b1_q, valid1;
  logic [15:0] cnt1;
  logic [3:0]  b4, b4_q;
  logic        valid4;
  logic [1:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic       m1_bq, m1_bprev;
  logic [3:0] m4_bq, m4_bprev;
  bit         m1_valid, m4_valid;
  int         m1_cnt, m4_cnt;

  not_gate_unit #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .b_q(b1_q),
    .valid_q(valid1), .clr(clr), .tog_cnt(cnt1)
  );

  not_gate_unit #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .b_q(b4_q),
    .valid_q(valid4), .clr(clr), .tog_cnt(cnt4)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: one step per rising edge, from the behavioural rules.
  always @(posedge clk) begin
    bit t1, t4;
    if (!rst_n) begin
      m1_bq = 1'b1; m1_bprev = 1'b1; m1_valid = 0; m1_cnt = 0;
      m4_bq = 4'hF; m4_bprev = 4'hF; m4_valid = 0; m4_cnt = 0;
    end else begin
      t1 = m1_valid && (m1_bq != m1_bprev);
      t4 = m4_valid && (m4_bq != m4_bprev);
      if (clr) m1_cnt = 0; else if (t1) m1_cnt = (m1_cnt + 1 > 65535) ? 65535 : m1_cnt + 1;
      if (clr) m4_cnt = 0; else if (t4) m4_cnt = (m4_cnt + 1 > 3) ? 3 : m4_cnt + 1;
      m1_bprev = m1_bq; m1_bq = ~a1; m1_valid = 1;
      m4_bprev = m4_bq; m4_bq = 4'hF - a4; m4_valid = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_idle();
    a1 = 1'b0; a4 = 4'h6;
    #1;
    n_tests++;
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL comb_a0: b=%b expected 1", b1); end
    n_tests++;
    if (b4 !== 4'h9) begin n_fail++; $display("FAIL comb_w4: b=%h expected 9", b4); end
    #4;
    a1 = 1'b1;
    #1;
    n_tests++;
    if (b1 !== 1'b0) begin n_fail++; $display("FAIL comb_a1: b=%b expected 0", b1); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a1 = 1'b1; a4 = 4'h0;
    clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (b1_q !== 1'b1 || valid1 !== 1'b0 || cnt1 !== 16'd0 || b1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_w1: b_q=%b valid=%b cnt=%0d b=%b expected 1 0 0 0", b1_q, valid1, cnt1, b1);
      end
      n_tests++;
      if (b4_q !== 4'hF || valid4 !== 1'b0 || cnt4 !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_w4: b_q=%h valid=%b cnt=%0d expected F 0 0", b4_q, valid4, cnt4);
      end
    end
  endtask

  task automatic test_registered();
    rst_n = 1'b1; a1 = 1'b0;
    tick();
    n_tests++;
    if (b1_q !== 1'b1 || valid1 !== 1'b1 || cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL reg_first: b_q=%b valid=%b cnt=%0d expected 1 1 0", b1_q, valid1, cnt1);
    end
    a1 = 1'b1;
    tick();
    n_tests++;
    if (b1_q !== 1'b0 || cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL reg_follow: b_q=%b cnt=%0d expected 0 0", b1_q, cnt1);
    end
    tick();
    n_tests++;
    if (cnt1 !== 16'd1 || cnt1 !== 16'(m1_cnt)) begin
      n_fail++; $display("FAIL reg_count: cnt=%0d expected 1 (model %0d)", cnt1, m1_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 6; i++) begin
      a4 = a4 ^ 4'($urandom_range(1, 15));
      tick();
      n_tests++;
      if (cnt4 !== 2'(m4_cnt) || b4_q !== m4_bq) begin
        n_fail++; $display("FAIL sat_step%0d: cnt=%0d b_q=%h expected %0d %h", i, cnt4, b4_q, m4_cnt, m4_bq);
      end
    end
    tick();
    n_tests++;
    if (cnt4 !== 2'd3) begin n_fail++; $display("FAIL sat_hold: cnt=%0d expected 3", cnt4); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) begin
      clr = 1'b1;
      a4 = a4 ^ 4'($urandom_range(1, 15));
      tick();
      n_tests++;
      if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL clr_%0d: cnt=%0d expected 0", i, cnt4); end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int guard = 0;
    while (m4_cnt != 2 && guard < 10) begin
      a4 = a4 ^ 4'($urandom_range(1, 15));
      tick();
      guard++;
    end
    n_tests++;
    if (cnt4 !== 2'd2) begin n_fail++; $display("FAIL mid_pre: cnt=%0d expected 2 (model %0d)", cnt4, m4_cnt); end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (cnt4 !== 2'd0 || b4_q !== 4'hF || valid4 !== 1'b0 || b4 !== ~a4) begin
      n_fail++; $display("FAIL mid_reset: cnt=%0d b_q=%h valid=%b b=%h expected 0 F 0 %h", cnt4, b4_q, valid4, b4, ~a4);
    end
    rst_n = 1'b1;
    a4 = 4'($urandom_range(1, 15));
    tick();
    n_tests++;
    if (cnt4 !== 2'd0 || valid4 !== 1'b1 || b4_q !== 4'hF - a4) begin
      n_fail++; $display("FAIL mid_release: cnt=%0d valid=%b b_q=%h expected 0 1 %h", cnt4, valid4, b4_q, 4'hF - a4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a1 = 1'($urandom);
      a4 = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 40) != 0);
      tick();
      n_tests++;
      if (b1_q !== m1_bq || valid1 !== m1_valid || cnt1 !== 16'(m1_cnt) ||
          b4_q !== m4_bq || valid4 !== m4_valid || cnt4 !== 2'(m4_cnt)) begin
        n_fail++;
        $display("FAIL rand_%0d: w1 %b %b %0d w4 %h %b %0d expected w1 %b %b %0d w4 %h %b %0d",
                 i, b1_q, valid1, cnt1, b4_q, valid4, cnt4,
                 m1_bq, m1_valid, m1_cnt, m4_bq, m4_valid, m4_cnt);
      end
    end
    clr = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      a4 = 4'(i);
      #1;
      n_tests++;
      if (b4 !== 4'(15 - i)) begin n_fail++; $display("FAIL sweep_%0d: b=%h expected %h", i, b4, 4'(15 - i)); end
    end
  endtask

  initial begin
    test_comb_idle();
    test_reset();
    test_registered();
    test_saturate();
    test_clr();
    test_reset_midrun();
    test_random();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
